// File: rtl/alu_issuer.sv
// ALU issue/capture sequencer with a 4x4 register file.
// Ports: instr_* in, wr_* RF write, alu_* to/from ALU, res_* out, op_count.
module alu_issuer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [2:0] instr_opcode,
  input  logic [1:0] instr_dst,
  input  logic [1:0] instr_srca,
  input  logic [1:0] instr_srcb,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [3:0] wr_data,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [2:0] alu_opcode,
  input  logic [3:0] alu_r,
  input  logic [3:0] alu_ccr,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [3:0] res_data,
  output logic [3:0] res_ccr,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] CNT_INIT =
    4'(SETTLE_CYCLES - 1);

  state_t     state;
  state_t     state_n;
  logic [3:0] rf [4];
  logic [3:0] cnt;
  logic [1:0] dst;
  logic       accept;
  logic       capture;
  logic       handoff;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    capture = 1'b0;
    handoff = 1'b0;
    unique case (state)
      IDLE: begin
        if (instr_valid) begin
          accept  = 1'b1;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          capture = 1'b1;
          state_n = RESP;
        end
      end
      RESP: begin
        // Hand-off always returns to IDLE,
        // so back-to-back ops get a gap cycle.
        if (res_ready) begin
          handoff = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign instr_ready = (state == IDLE);
  assign res_valid   = (state == RESP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opcode <= '0;
      cnt        <= '0;
      dst        <= '0;
      res_data   <= '0;
      res_ccr    <= '0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        // rf read here sees pre-edge contents
        alu_a      <= rf[instr_srca];
        alu_b      <= rf[instr_srcb];
        alu_opcode <= instr_opcode;
        dst        <= instr_dst;
        cnt        <= CNT_INIT;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        res_data <= alu_r;
        res_ccr  <= alu_ccr;
      end
      if (handoff) begin
        op_count <= op_count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        rf[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        rf[wr_addr] <= wr_data;
      end
      // Later assignment: ALU writeback wins a collision.
      if (capture) begin
        rf[dst] <= alu_r;
      end
    end
  end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed testbench for alu_issuer with a behavioural CVNZ ALU.
// Checks reset, latency, hold, RF collisions, mid-op reset, wrap.
module tb_alu_issuer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_opcode;
  logic [1:0] instr_dst;
  logic [1:0] instr_srca;
  logic [1:0] instr_srcb;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic [3:0] alu_r;
  logic [3:0] alu_ccr;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] res_data;
  logic [3:0] res_ccr;
  logic [7:0] op_count;

  int tests;
  int fails;

  alu_issuer #(.SETTLE_CYCLES(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr_opcode (instr_opcode),
    .instr_dst    (instr_dst),
    .instr_srca   (instr_srca),
    .instr_srcb   (instr_srcb),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_r        (alu_r),
    .alu_ccr      (alu_ccr),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_ccr      (res_ccr),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] t5;
  logic       fc;
  logic       fv;

  always_comb begin
    t5    = '0;
    fc    = 1'b0;
    fv    = 1'b0;
    alu_r = '0;
    case (alu_opcode)
      3'd0: begin
        t5    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_r = t5[3:0];
        fc    = t5[4];
        fv    = (alu_a[3] == alu_b[3]) &&
                (alu_r[3] != alu_a[3]);
      end
      3'd1: begin
        t5    = {1'b0, alu_a} - {1'b0, alu_b};
        alu_r = t5[3:0];
        fc    = t5[4];
        fv    = (alu_a[3] != alu_b[3]) &&
                (alu_r[3] != alu_a[3]);
      end
      3'd2: alu_r = alu_a & alu_b;
      3'd3: alu_r = alu_a | alu_b;
      3'd4: alu_r = ~alu_a;
      3'd5: alu_r = alu_a ^ alu_b;
      3'd6: begin
        alu_r = 4'd0 - alu_a;
        fv    = (alu_a == 4'h8);
      end
      default: begin
        alu_r = {alu_a[2:0], 1'b0};
        fc    = alu_a[3];
      end
    endcase
    alu_ccr = {fc, fv, alu_r[3], alu_r == 4'd0};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [3:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic run_op(input logic [2:0] op,
                        input logic [1:0] d,
                        input logic [1:0] sa,
                        input logic [1:0] sb,
                        output logic [3:0] r,
                        output logic [3:0] f);
    int n;
    n = 0;
    while (!instr_ready && n < 20) begin
      tick();
      n++;
    end
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_dst    = d;
    instr_srca   = sa;
    instr_srcb   = sb;
    tick();
    instr_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    if (!res_valid) begin
      tests++;
      fails++;
      $display("FAIL op_timeout res_valid=%b required 1",
               res_valid);
    end
    r = res_data;
    f = res_ccr;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic read_rf(input logic [1:0] idx,
                         output logic [3:0] v);
    logic [3:0] f;
    run_op(3'd3, idx, idx, idx, v, f);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (alu_a !== 4'd0 || alu_b !== 4'd0 ||
        alu_opcode !== 3'd0) begin
      fails++;
      $display("FAIL reset_ops a=%h b=%h op=%h required 0",
               alu_a, alu_b, alu_opcode);
    end
    tests++;
    if (res_data !== 4'd0 || res_ccr !== 4'd0 ||
        op_count !== 8'd0) begin
      fails++;
      $display("FAIL reset_res d=%h c=%h n=%h required 0",
               res_data, res_ccr, op_count);
    end
    tests++;
    if (instr_ready !== 1'b1 || res_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs rdy=%b vld=%b required 1/0",
               instr_ready, res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sum();
    logic [3:0] v;
    wr(2'd0, 4'd3);
    wr(2'd1, 4'd5);
    instr_valid  = 1'b1;
    instr_opcode = 3'd0;
    instr_dst    = 2'd2;
    instr_srca   = 2'd0;
    instr_srcb   = 2'd1;
    tick();
    instr_valid = 1'b0;
    tests++;
    if (alu_a !== 4'd3 || alu_b !== 4'd5 ||
        res_valid !== 1'b0) begin
      fails++;
      $display("FAIL sum_accept a=%h b=%h v=%b required 3 5 0",
               alu_a, alu_b, res_valid);
    end
    tick();
    tests++;
    if (res_valid !== 1'b0) begin
      fails++;
      $display("FAIL sum_early res_valid=%b required 0",
               res_valid);
    end
    tick();
    tests++;
    if (res_valid !== 1'b1 || res_data !== 4'd8 ||
        res_ccr !== 4'b0110) begin
      fails++;
      $display("FAIL sum_res v=%b d=%h c=%b required 1 8 0110",
               res_valid, res_data, res_ccr);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    tests++;
    if (op_count !== 8'd1 || instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL sum_count n=%0d rdy=%b required 1 1",
               op_count, instr_ready);
    end
    read_rf(2'd2, v);
    tests++;
    if (v !== 4'd8) begin
      fails++;
      $display("FAIL sum_rf2 got=%h required 8", v);
    end
  endtask

  task automatic test_hold();
    wr(2'd0, 4'd5);
    wr(2'd1, 4'd5);
    instr_valid  = 1'b1;
    instr_opcode = 3'd1;
    instr_dst    = 2'd3;
    instr_srca   = 2'd0;
    instr_srcb   = 2'd1;
    tick();
    instr_opcode = 3'd5;
    tick();
    tick();
    tests++;
    if (res_valid !== 1'b1 || res_data !== 4'd0 ||
        res_ccr !== 4'b0001) begin
      fails++;
      $display("FAIL hold_res v=%b d=%h c=%b required 1 0 0001",
               res_valid, res_data, res_ccr);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (res_valid !== 1'b1 || res_data !== 4'd0 ||
          res_ccr !== 4'b0001 || instr_ready !== 1'b0 ||
          alu_opcode !== 3'd1) begin
        fails++;
        $display("FAIL hold_%0d v=%b d=%h c=%b r=%b op=%h req 1 0 0001 0 1",
                 i, res_valid, res_data, res_ccr,
                 instr_ready, alu_opcode);
      end
    end
    instr_valid = 1'b0;
    res_ready   = 1'b1;
    tick();
    res_ready = 1'b0;
    tests++;
    if (op_count !== 8'd3) begin
      fails++;
      $display("FAIL hold_count n=%0d required 3", op_count);
    end
  endtask

  task automatic test_collide();
    logic [3:0] v;
    wr(2'd0, 4'd2);
    wr(2'd1, 4'd4);
    instr_valid  = 1'b1;
    instr_opcode = 3'd0;
    instr_dst    = 2'd1;
    instr_srca   = 2'd0;
    instr_srcb   = 2'd0;
    tick();
    instr_valid = 1'b0;
    tick();
    wr(2'd1, 4'hF);
    tests++;
    if (res_valid !== 1'b1 || res_data !== 4'd4) begin
      fails++;
      $display("FAIL coll_res v=%b d=%h required 1 4",
               res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    read_rf(2'd1, v);
    tests++;
    if (v !== 4'd4) begin
      fails++;
      $display("FAIL coll_same rf1=%h required 4", v);
    end
    instr_valid  = 1'b1;
    instr_opcode = 3'd5;
    instr_dst    = 2'd1;
    instr_srca   = 2'd0;
    instr_srcb   = 2'd1;
    tick();
    instr_valid = 1'b0;
    tick();
    wr(2'd0, 4'hF);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    read_rf(2'd1, v);
    tests++;
    if (v !== 4'd6) begin
      fails++;
      $display("FAIL coll_diff_rf1 got=%h required 6", v);
    end
    read_rf(2'd0, v);
    tests++;
    if (v !== 4'hF) begin
      fails++;
      $display("FAIL coll_diff_rf0 got=%h required F", v);
    end
  endtask

  task automatic test_wait_write();
    logic [3:0] r;
    logic [3:0] f;
    int n;
    instr_valid  = 1'b1;
    instr_opcode = 3'd0;
    instr_dst    = 2'd3;
    instr_srca   = 2'd0;
    instr_srcb   = 2'd1;
    tick();
    instr_valid = 1'b0;
    wr(2'd0, 4'd0);
    tests++;
    if (alu_a !== 4'hF) begin
      fails++;
      $display("FAIL wwait_opnd alu_a=%h required F", alu_a);
    end
    n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    tests++;
    if (res_data !== 4'd5 || res_ccr !== 4'b1000) begin
      fails++;
      $display("FAIL wwait_res d=%h c=%b required 5 1000",
               res_data, res_ccr);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    read_rf(2'd0, r);
    f = r;
    tests++;
    if (f !== 4'd0) begin
      fails++;
      $display("FAIL wwait_rf0 got=%h required 0", f);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] v;
    logic [3:0] f;
    wr(2'd2, 4'd9);
    instr_valid  = 1'b1;
    instr_opcode = 3'd0;
    instr_dst    = 2'd2;
    instr_srca   = 2'd2;
    instr_srcb   = 2'd2;
    tick();
    instr_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (alu_a !== 4'd0 || alu_b !== 4'd0 ||
        alu_opcode !== 3'd0 || res_data !== 4'd0 ||
        res_ccr !== 4'd0 || op_count !== 8'd0) begin
      fails++;
      $display("FAIL mid_reset a=%h b=%h d=%h c=%h n=%0d req 0",
               alu_a, alu_b, res_data, res_ccr, op_count);
    end
    tests++;
    if (res_valid !== 1'b0 || instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_reset_hs v=%b r=%b required 0 1",
               res_valid, instr_ready);
    end
    #2;
    rst_n = 1'b1;
    instr_valid  = 1'b1;
    instr_opcode = 3'd3;
    instr_dst    = 2'd2;
    instr_srca   = 2'd2;
    instr_srcb   = 2'd2;
    tick();
    instr_valid = 1'b0;
    tests++;
    if (instr_ready !== 1'b0 || alu_opcode !== 3'd3) begin
      fails++;
      $display("FAIL mid_first_accept r=%b op=%h required 0 3",
               instr_ready, alu_opcode);
    end
    tick();
    tick();
    tests++;
    if (res_valid !== 1'b1 || res_data !== 4'd0) begin
      fails++;
      $display("FAIL mid_rf2 v=%b d=%h required 1 0",
               res_valid, res_data);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    read_rf(2'd2, v);
    f = v;
    tests++;
    if (f !== 4'd0 || op_count !== 8'd2) begin
      fails++;
      $display("FAIL mid_after rf2=%h n=%0d required 0 2",
               f, op_count);
    end
  endtask

  task automatic test_back_to_back();
    int idle_n;
    int resp_n;
    idle_n = 0;
    resp_n = 0;
    instr_valid  = 1'b1;
    instr_opcode = 3'd3;
    instr_dst    = 2'd0;
    instr_srca   = 2'd0;
    instr_srcb   = 2'd0;
    res_ready    = 1'b1;
    for (int i = 0; i < 4 * 254; i++) begin
      if (instr_ready) idle_n++;
      if (res_valid) resp_n++;
      tick();
    end
    instr_valid = 1'b0;
    res_ready   = 1'b0;
    tests++;
    if (idle_n != 254 || resp_n != 254) begin
      fails++;
      $display("FAIL b2b_cycles idle=%0d resp=%0d required 254",
               idle_n, resp_n);
    end
    tests++;
    if (op_count !== 8'd0 || instr_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_wrap n=%0d r=%b required 0 1",
               op_count, instr_ready);
    end
  endtask

  initial begin
    tests        = 0;
    fails        = 0;
    instr_valid  = 1'b0;
    instr_opcode = '0;
    instr_dst    = '0;
    instr_srca   = '0;
    instr_srcb   = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    res_ready    = 1'b0;
    test_reset();
    test_sum();
    test_hold();
    test_collide();
    test_wait_write();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
